// File: rtl/pc_seq_pkg.sv
// Shared types and default sizing for the program sequencer.
// Pure declarations: no logic, no latency.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } seq_state_t;

  localparam int DEF_PC_W        = 12;
  localparam int DEF_TAG_W       = 8;
  localparam int DEF_LUT_DEPTH   = 32;
  localparam int DEF_STACK_DEPTH = 4;
  localparam int DEF_CYC_W       = 16;
  localparam int DEF_START_PC    = 0;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO: push/pop/clear take effect at the clock edge, top is a flop read.
// No backpressure: the owner must not push when full or pop when empty (such requests are dropped).
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_dat,
  output logic [W-1:0] top_dat,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] sp_q, sp_d;

  assign full    = (sp_q == PW'(DEPTH));
  assign empty   = (sp_q == '0);
  assign top_dat = mem_q[IW'(sp_q - PW'(1))];

  always_comb begin
    mem_d = mem_q;
    sp_d  = sp_q;
    if (clr) begin
      sp_d = '0;
    end else if (push && !full) begin
      mem_d[IW'(sp_q)] = push_dat;
      sp_d             = sp_q + PW'(1);
    end else if (pop && !empty) begin
      sp_d = sp_q - PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q  <= '0;
      mem_q <= '{default: '0};
    end else begin
      sp_q  <= sp_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program sequencer: PC, writable branch-target table, return stack and run handshake.
// Every output is a flop updated one edge after its controlling inputs; no backpressure beyond stall.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int PC_W        = DEF_PC_W,
  parameter int TAG_W       = DEF_TAG_W,
  parameter int LUT_DEPTH   = DEF_LUT_DEPTH,
  parameter int STACK_DEPTH = DEF_STACK_DEPTH,
  parameter int CYC_W       = DEF_CYC_W,
  parameter int START_PC    = DEF_START_PC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             halt,
  input  logic             stall,
  input  logic             br_en,
  input  logic             call_en,
  input  logic             ret_en,
  input  logic [TAG_W-1:0] br_tag,
  input  logic             lut_we,
  input  logic [TAG_W-1:0] lut_waddr,
  input  logic [PC_W-1:0]  lut_wdata,
  output logic [PC_W-1:0]  prog_ctr,
  output logic             running,
  output logic             done,
  output logic             fault,
  output logic [CYC_W-1:0] cycle_cnt
);

  localparam int LUT_AW = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1;
  localparam logic [TAG_W:0] LUT_LIMIT = (TAG_W + 1)'(LUT_DEPTH);

  seq_state_t       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CYC_W-1:0] cnt_q, cnt_d;
  logic             running_q, running_d;
  logic             done_q, done_d;
  logic             fault_q, fault_d;
  logic [PC_W-1:0]  lut_q [LUT_DEPTH];
  logic [PC_W-1:0]  lut_d [LUT_DEPTH];

  logic             stk_clr, stk_push, stk_pop, stk_full, stk_empty;
  logic [PC_W-1:0]  stk_top;
  logic             tag_ok;
  logic [PC_W-1:0]  lut_tgt;

  ret_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (PC_W)
  ) u_ret_stack (
    .clk      (clk),
    .rst_n    (reset),
    .clr      (stk_clr),
    .push     (stk_push),
    .pop      (stk_pop),
    .push_dat (pc_q + PC_W'(1)),
    .top_dat  (stk_top),
    .full     (stk_full),
    .empty    (stk_empty)
  );

  // Lookup reads the pre-write table, so a same-cycle write never bypasses.
  assign tag_ok  = ({1'b0, br_tag} < LUT_LIMIT);
  assign lut_tgt = lut_q[LUT_AW'(br_tag)];

  always_comb begin
    lut_d = lut_q;
    if (lut_we && ({1'b0, lut_waddr} < LUT_LIMIT)) begin
      lut_d[LUT_AW'(lut_waddr)] = lut_wdata;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    stk_clr  = 1'b0;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    case (state_q)
      RUN: begin
        if (cnt_q != '1) cnt_d = cnt_q + CYC_W'(1);
        if (halt) begin
          state_d = DONE;
        end else if (!stall) begin
          if (ret_en) begin
            if (stk_empty) begin
              state_d = FAULT;
            end else begin
              pc_d    = stk_top;
              stk_pop = 1'b1;
            end
          end else if (call_en) begin
            if (stk_full || !tag_ok) begin
              state_d = FAULT;
            end else begin
              pc_d     = lut_tgt;
              stk_push = 1'b1;
            end
          end else if (br_en) begin
            if (!tag_ok) state_d = FAULT;
            else         pc_d    = lut_tgt;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      default: begin
        if (req) begin
          state_d = RUN;
          pc_d    = PC_W'(START_PC);
          cnt_d   = '0;
          stk_clr = 1'b1;
        end
      end
    endcase
    running_d = (state_d == RUN);
    done_d    = (state_d == DONE) || (state_d == FAULT);
    fault_d   = (state_d == FAULT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
      lut_q     <= '{default: '0};
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      running_q <= running_d;
      done_q    <= done_d;
      fault_q   <= fault_d;
      lut_q     <= lut_d;
    end
  end

  assign prog_ctr  = pc_q;
  assign running   = running_q;
  assign done      = done_q;
  assign fault     = fault_q;
  assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios then random traffic, all checked
// against a queue/array reference model of the sequencing rules.
module tb_pc_sequencer;

  localparam int PC_W        = 12;
  localparam int TAG_W       = 8;
  localparam int LUT_DEPTH   = 32;
  localparam int STACK_DEPTH = 4;
  localparam int CYC_W       = 16;
  localparam int START_PC    = 0;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DONE  = 2;
  localparam int M_FAULT = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             req, halt, stall, br_en, call_en, ret_en, lut_we;
  logic [TAG_W-1:0] br_tag, lut_waddr;
  logic [PC_W-1:0]  lut_wdata;
  logic [PC_W-1:0]  prog_ctr;
  logic             running, done, fault;
  logic [CYC_W-1:0] cycle_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  int          m_mode;
  int unsigned m_pc, m_cnt;
  int unsigned m_stack[$];
  int unsigned m_lut[LUT_DEPTH];

  always #5 clk = ~clk;

  pc_sequencer #(
    .PC_W        (PC_W),
    .TAG_W       (TAG_W),
    .LUT_DEPTH   (LUT_DEPTH),
    .STACK_DEPTH (STACK_DEPTH),
    .CYC_W       (CYC_W),
    .START_PC    (START_PC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .halt      (halt),
    .stall     (stall),
    .br_en     (br_en),
    .call_en   (call_en),
    .ret_en    (ret_en),
    .br_tag    (br_tag),
    .lut_we    (lut_we),
    .lut_waddr (lut_waddr),
    .lut_wdata (lut_wdata),
    .prog_ctr  (prog_ctr),
    .running   (running),
    .done      (done),
    .fault     (fault),
    .cycle_cnt (cycle_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m_pc   = 0;
    m_cnt  = 0;
    m_stack.delete();
    foreach (m_lut[i]) m_lut[i] = 0;
  endtask

  // One clock edge of the sequencing rules, using the inputs present at the edge.
  task automatic model_edge();
    int unsigned pc_mod, cnt_max, tgt;
    bit          tag_ok;
    pc_mod  = 1 << PC_W;
    cnt_max = (1 << CYC_W) - 1;
    tag_ok  = (int'(br_tag) < LUT_DEPTH);
    tgt     = tag_ok ? m_lut[int'(br_tag)] : 0;
    if (m_mode == M_RUN) begin
      if (m_cnt < cnt_max) m_cnt = m_cnt + 1;
      if (halt) begin
        m_mode = M_DONE;
      end else if (!stall) begin
        if (ret_en) begin
          if (m_stack.size() == 0) m_mode = M_FAULT;
          else                     m_pc   = m_stack.pop_back();
        end else if (call_en) begin
          if (m_stack.size() == STACK_DEPTH || !tag_ok) begin
            m_mode = M_FAULT;
          end else begin
            m_stack.push_back((m_pc + 1) % pc_mod);
            m_pc = tgt;
          end
        end else if (br_en) begin
          if (!tag_ok) m_mode = M_FAULT;
          else         m_pc   = tgt;
        end else begin
          m_pc = (m_pc + 1) % pc_mod;
        end
      end
    end else if (req) begin
      m_mode = M_RUN;
      m_pc   = START_PC;
      m_cnt  = 0;
      m_stack.delete();
    end
    if (lut_we && int'(lut_waddr) < LUT_DEPTH) m_lut[int'(lut_waddr)] = int'(lut_wdata);
  endtask

  task automatic compare_all();
    check_eq("prog_ctr",  prog_ctr,  m_pc);
    check_eq("running",   running,   m_mode == M_RUN);
    check_eq("done",      done,      m_mode == M_DONE || m_mode == M_FAULT);
    check_eq("fault",     fault,     m_mode == M_FAULT);
    check_eq("cycle_cnt", cycle_cnt, m_cnt);
  endtask

  task automatic clr_in();
    req = 0; halt = 0; stall = 0; br_en = 0; call_en = 0; ret_en = 0;
    br_tag = '0; lut_we = 0; lut_waddr = '0; lut_wdata = '0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic async_reset();
    reset = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic lut_write(input int addr, input int data);
    lut_we = 1; lut_waddr = TAG_W'(addr); lut_wdata = PC_W'(data);
    step();
    lut_we = 0;
  endtask

  initial begin
    clr_in();
    reset = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    reset = 1'b1;
    step();

    // Start and free-run
    req = 1; step(); req = 0;
    check_eq("start_pc", prog_ctr, START_PC);
    repeat (5) step();
    check_eq("run5_cnt", cycle_cnt, 5);
    check_eq("run5_pc", prog_ctr, 5);
    check_eq("run5_done", done, 0);

    // Branch and write/lookup collision
    lut_write(3, 'h040);
    br_en = 1; br_tag = 3; step();
    check_eq("branch_tgt", prog_ctr, 'h040);
    lut_we = 1; lut_waddr = 3; lut_wdata = 'h050; step(); lut_we = 0;
    check_eq("wr_rd_old", prog_ctr, 'h040);
    step();
    check_eq("branch_new", prog_ctr, 'h050);
    br_en = 0;

    // Call / return / overflow
    lut_write(4, 'h010);
    lut_write(3, 'h040);
    br_en = 1; br_tag = 4; step(); br_en = 0;
    check_eq("pc_at_010", prog_ctr, 'h010);
    call_en = 1; br_tag = 3; step(); call_en = 0;
    check_eq("call_tgt", prog_ctr, 'h040);
    step();
    ret_en = 1; step(); ret_en = 0;
    check_eq("ret_addr", prog_ctr, 'h011);
    call_en = 1; br_tag = 3;
    repeat (4) step();
    check_eq("call4_fault", fault, 0);
    step(); call_en = 0;
    check_eq("call5_fault", fault, 1);
    check_eq("call5_done", done, 1);

    // Stall, halt under stall, restart
    req = 1; step(); req = 0;
    repeat (2) step();
    stall = 1; br_en = 1; br_tag = 3;
    repeat (3) step();
    check_eq("stall_pc", prog_ctr, 2);
    check_eq("stall_cnt", cycle_cnt, 5);
    halt = 1; step(); halt = 0;
    check_eq("halt_done", done, 1);
    check_eq("halt_running", running, 0);
    stall = 0; br_en = 0; step();
    check_eq("done_hold", done, 1);
    req = 1; step(); req = 0;
    check_eq("restart_pc", prog_ctr, START_PC);
    check_eq("restart_done", done, 0);

    // Wrap and out-of-range tag
    lut_write(5, 'hFFF);
    br_en = 1; br_tag = 5; step(); br_en = 0;
    check_eq("pc_fff", prog_ctr, 'hFFF);
    step();
    check_eq("wrap_pc", prog_ctr, 0);
    check_eq("wrap_fault", fault, 0);
    br_en = 1; br_tag = 40; step(); br_en = 0;
    check_eq("tag_range_fault", fault, 1);

    // Return with empty stack
    req = 1; step(); req = 0;
    ret_en = 1; step(); ret_en = 0;
    check_eq("ret_empty_fault", fault, 1);

    // Asynchronous reset mid-run clears the table
    req = 1; step(); req = 0;
    lut_write(6, 'h123);
    br_en = 1; br_tag = 6; step(); br_en = 0;
    check_eq("pc_123", prog_ctr, 'h123);
    async_reset();
    check_eq("rst_pc", prog_ctr, 0);
    check_eq("rst_running", running, 0);
    req = 1; step(); req = 0;
    lut_write(35, 'h777);
    br_en = 1; br_tag = 3; step(); br_en = 0;
    check_eq("lut_cleared", prog_ctr, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      req       = ($urandom_range(0, 19) == 0);
      halt      = ($urandom_range(0, 39) == 0);
      stall     = ($urandom_range(0, 6) == 0);
      ret_en    = ($urandom_range(0, 7) == 0);
      call_en   = ($urandom_range(0, 7) == 0);
      br_en     = ($urandom_range(0, 5) == 0);
      br_tag    = ($urandom_range(0, 9) == 0) ? TAG_W'($urandom_range(32, 255))
                                              : TAG_W'($urandom_range(0, 31));
      lut_we    = ($urandom_range(0, 2) == 0);
      lut_waddr = ($urandom_range(0, 9) == 0) ? TAG_W'($urandom_range(32, 255))
                                              : TAG_W'($urandom_range(0, 31));
      lut_wdata = PC_W'($urandom);
      if ($urandom_range(0, 999) == 0) async_reset();
      else                             step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
